// File: rtl/instruction_prefetch_unit.sv
// Instruction fetch unit: streams microcode ROM words into a small prefetch
// queue ahead of decode, stalling at branches until execute resolves them.
module instruction_prefetch_unit #(
    parameter int ADDR_W     = 16,
    parameter int INSTR_W    = 64,
    parameter int OP_LEN     = 8,
    parameter int QDEPTH     = 4,
    parameter int JUMP_OP_LO = 1,
    parameter int JUMP_OP_HI = 12
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               iTrigger,
    input  logic [ADDR_W-1:0]  iInitialCodeAddress,
    output logic               oRomRead,
    output logic [ADDR_W-1:0]  oRomAddress,
    input  logic [INSTR_W-1:0] iRomData,
    output logic               oInstructionValid,
    output logic [INSTR_W-1:0] oInstruction,
    output logic [ADDR_W-1:0]  oInstructionPointer,
    input  logic               iDecodeReady,
    input  logic               iBranchTaken,
    input  logic               iBranchNotTaken,
    input  logic [ADDR_W-1:0]  iJumpIp,
    input  logic               iExeBusy,
    input  logic               iIDUBusy,
    output logic               oBusy,
    output logic               oExecutionDone
);
    localparam int PTR_W = $clog2(QDEPTH);

    typedef enum logic [2:0] {IDLE, FETCH, BRANCH_WAIT, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  ip;
    } entry_t;

    state_t            state;
    entry_t            queue [QDEPTH];
    entry_t            lastHead;
    entry_t            head;
    logic [PTR_W-1:0]  rdPtr, wrPtr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] pc, inFlightIp;
    logic              inFlight;

    logic [OP_LEN-1:0] opcode;
    logic              isReturn, isBranch, romRead, push, pop, stopWord;

    always_comb begin
        opcode   = iRomData[INSTR_W-1 -: OP_LEN];
        isReturn = (opcode == '0);
        isBranch = (int'(opcode) >= JUMP_OP_LO) && (int'(opcode) <= JUMP_OP_HI);
        // inFlight marks that iRomData carries a live word this cycle
        push     = inFlight;
        stopWord = push && (isBranch || isReturn);
        pop      = (count != '0) && iDecodeReady;
        // the outstanding read counts against capacity so nothing is overwritten
        romRead  = (state == FETCH) && (int'(count) + int'(inFlight) < QDEPTH);
        // an empty queue keeps presenting the last accepted entry
        head     = (count != '0) ? queue[rdPtr] : lastHead;
    end

    assign oRomRead            = romRead;
    assign oRomAddress         = pc;
    assign oInstructionValid   = (count != '0);
    assign oInstruction        = head.instr;
    assign oInstructionPointer = head.ip;
    assign oBusy               = (state != IDLE);
    assign oExecutionDone      = (state == DONE) && !iExeBusy && !iIDUBusy;

    always_ff @(posedge Clock) begin
        if (push)
            queue[wrPtr] <= '{instr: iRomData, ip: inFlightIp};
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            pc         <= '0;
            inFlight   <= 1'b0;
            inFlightIp <= '0;
            rdPtr      <= '0;
            wrPtr      <= '0;
            count      <= '0;
            lastHead   <= '0;
        end else begin
            // a read issued alongside a branch/return word is squashed
            inFlight <= romRead && !stopWord;
            if (romRead)
                inFlightIp <= pc;
            if (push)
                wrPtr <= wrPtr + PTR_W'(1);
            if (pop) begin
                rdPtr    <= rdPtr + PTR_W'(1);
                lastHead <= queue[rdPtr];
            end
            count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);

            case (state)
                IDLE: begin
                    if (iTrigger) begin
                        pc    <= iInitialCodeAddress;
                        rdPtr <= '0;
                        wrPtr <= '0;
                        count <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (romRead)
                        pc <= pc + ADDR_W'(1);
                    if (push && isBranch) begin
                        pc    <= inFlightIp + ADDR_W'(1);
                        state <= BRANCH_WAIT;
                    end else if (push && isReturn) begin
                        state <= DRAIN;
                    end
                end
                BRANCH_WAIT: begin
                    // nothing younger than the branch is ever queued, so taken needs no flush
                    if (iBranchNotTaken) begin
                        state <= FETCH;
                    end else if (iBranchTaken) begin
                        pc    <= iJumpIp;
                        state <= FETCH;
                    end
                end
                DRAIN: begin
                    // the RETURN is the youngest entry, so empty means it was accepted
                    if (count == '0)
                        state <= DONE;
                end
                DONE: begin
                    if (!iExeBusy && !iIDUBusy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_instruction_prefetch_unit.sv
// Directed bench for instruction_prefetch_unit: a registered ROM model feeds
// the DUT while a negedge monitor logs ROM reads, decode accepts and done pulses.
`timescale 1ns/1ps
module tb_instruction_prefetch_unit;
    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iTrigger = 1'b0;
    logic [15:0] iInitialCodeAddress = '0;
    logic        oRomRead;
    logic [15:0] oRomAddress;
    logic [63:0] iRomData = '0;
    logic        oInstructionValid;
    logic [63:0] oInstruction;
    logic [15:0] oInstructionPointer;
    logic        iDecodeReady = 1'b0;
    logic        iBranchTaken = 1'b0;
    logic        iBranchNotTaken = 1'b0;
    logic [15:0] iJumpIp = '0;
    logic        iExeBusy = 1'b0;
    logic        iIDUBusy = 1'b0;
    logic        oBusy;
    logic        oExecutionDone;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t0 = 0;

    logic [63:0] rom [logic [15:0]];
    logic [15:0] readAddr [$];
    int          readCyc [$];
    logic [15:0] accIp [$];
    logic [63:0] accInstr [$];
    int          accCyc [$];
    int          doneCyc [$];

    instruction_prefetch_unit dut (
        .Clock(Clock), .Reset(Reset), .iTrigger(iTrigger),
        .iInitialCodeAddress(iInitialCodeAddress),
        .oRomRead(oRomRead), .oRomAddress(oRomAddress), .iRomData(iRomData),
        .oInstructionValid(oInstructionValid), .oInstruction(oInstruction),
        .oInstructionPointer(oInstructionPointer), .iDecodeReady(iDecodeReady),
        .iBranchTaken(iBranchTaken), .iBranchNotTaken(iBranchNotTaken), .iJumpIp(iJumpIp),
        .iExeBusy(iExeBusy), .iIDUBusy(iIDUBusy), .oBusy(oBusy), .oExecutionDone(oExecutionDone)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [63:0] word(logic [7:0] op, logic [15:0] a);
        return {op, 40'h0, a};
    endfunction

    // unlisted addresses hold an ADD (opcode 0x20) tagged with its own address
    function automatic logic [63:0] romAt(logic [15:0] a);
        if (rom.exists(a)) return rom[a];
        return word(8'h20, a);
    endfunction

    always @(posedge Clock) if (oRomRead) iRomData <= romAt(oRomAddress);

    always @(negedge Clock) begin
        if (Reset) begin
            if (oRomRead) begin
                readAddr.push_back(oRomAddress);
                readCyc.push_back(cyc);
            end
            if (oInstructionValid && iDecodeReady) begin
                accIp.push_back(oInstructionPointer);
                accInstr.push_back(oInstruction);
                accCyc.push_back(cyc);
            end
            if (oExecutionDone) doneCyc.push_back(cyc);
        end
    end

    function automatic logic [63:0] accIpAt(int i);
        return (i < accIp.size()) ? {48'h0, accIp[i]} : 64'hDEAD_0000;
    endfunction
    function automatic logic [63:0] accInstrAt(int i);
        return (i < accInstr.size()) ? accInstr[i] : 64'hDEAD_0001;
    endfunction
    function automatic int accCycAt(int i);
        return (i < accCyc.size()) ? accCyc[i] : -1;
    endfunction
    function automatic logic [63:0] readAt(int i);
        return (i < readAddr.size()) ? {48'h0, readAddr[i]} : 64'hDEAD_0002;
    endfunction
    function automatic int readCycAt(int i);
        return (i < readCyc.size()) ? readCyc[i] : -1;
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic clearLogs();
        readAddr.delete(); readCyc.delete();
        accIp.delete(); accInstr.delete(); accCyc.delete(); doneCyc.delete();
    endtask

    task automatic start(logic [15:0] a);
        iInitialCodeAddress = a;
        iTrigger = 1'b1;
        t0 = cyc;
        tick();
        iTrigger = 1'b0;
    endtask

    task automatic waitIdle(string tag);
        int n = 0;
        while (oBusy && n < 200) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {63'h0, oBusy}, 64'h0);
    endtask

    task automatic chkOutputsZero(string tag);
        chk({tag, "_read"},  {63'h0, oRomRead}, 64'h0);
        chk({tag, "_addr"},  {48'h0, oRomAddress}, 64'h0);
        chk({tag, "_valid"}, {63'h0, oInstructionValid}, 64'h0);
        chk({tag, "_instr"}, oInstruction, 64'h0);
        chk({tag, "_ip"},    {48'h0, oInstructionPointer}, 64'h0);
        chk({tag, "_busy"},  {63'h0, oBusy}, 64'h0);
        chk({tag, "_done"},  {63'h0, oExecutionDone}, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rom[16'h0012] = word(8'h00, 16'h0012);
        rom[16'h0106] = word(8'h00, 16'h0106);
        rom[16'h0020] = word(8'h05, 16'h0020);
        rom[16'h0022] = word(8'h00, 16'h0022);
        rom[16'h0041] = word(8'h00, 16'h0041);
        rom[16'h0000] = word(8'h00, 16'h0000);
        rom[16'h0301] = word(8'h00, 16'h0301);

        tick(2);
        chkOutputsZero("rst");
        Reset = 1'b1;
        tick(2);

        // straight-line run ending in RETURN, completion held off by busy flags
        clearLogs();
        iDecodeReady = 1'b1; iExeBusy = 1'b1; iIDUBusy = 1'b1;
        start(16'h0010);
        tick(11);
        chk("t1_nacc", accIp.size(), 3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_ip", accIpAt(i), 64'h10 + i);
            chk("t1_cyc", accCycAt(i), t0 + 3 + i);
        end
        chk("t1_nodone", doneCyc.size(), 0);
        chk("t1_busy", {63'h0, oBusy}, 64'h1);
        iExeBusy = 1'b0;
        tick();
        iIDUBusy = 1'b0;
        t = cyc;
        tick();
        chk("t1_ndone", doneCyc.size(), 1);
        chk("t1_donecyc", (doneCyc.size() > 0) ? doneCyc[0] : -1, t);
        chk("t1_busyfall", {63'h0, oBusy}, 64'h0);

        // decode stalled: queue fills to QDEPTH and reads stop
        clearLogs();
        iDecodeReady = 1'b0;
        start(16'h0100);
        tick(9);
        chk("t2_nread", readAddr.size(), 4);
        for (int i = 0; i < 4; i++) chk("t2_raddr", readAt(i), 64'h100 + i);
        chk("t2_valid", {63'h0, oInstructionValid}, 64'h1);
        chk("t2_head", {48'h0, oInstructionPointer}, 64'h100);
        chk("t2_fullnoread", {63'h0, oRomRead}, 64'h0);
        chk("t2_nacc0", accIp.size(), 0);
        tick();
        iDecodeReady = 1'b1;
        waitIdle("t2");
        chk("t2_nacc", accIp.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk("t2_ip", accIpAt(i), 64'h100 + i);
            chk("t2_word", accInstrAt(i) & 64'hFFFF, 64'h100 + i);
            chk("t2_cyc", accCycAt(i), t0 + 11 + i);
        end
        chk("t2_resume_addr", readAt(4), 64'h104);
        chk("t2_resume_cyc", readCycAt(4), t0 + 12);
        chk("t2_holdvalid", {63'h0, oInstructionValid}, 64'h0);
        chk("t2_holdinstr", oInstruction, word(8'h00, 16'h0106));
        chk("t2_holdip", {48'h0, oInstructionPointer}, 64'h106);

        // branch at 0x20 resolved taken to 0x40; a stray early pulse is ignored
        clearLogs();
        start(16'h001E);
        iBranchTaken = 1'b1; iJumpIp = 16'h0077;
        tick();
        iBranchTaken = 1'b0;
        tick(6);
        iBranchTaken = 1'b1; iJumpIp = 16'h0040;
        t = cyc;
        tick();
        iBranchTaken = 1'b0;
        waitIdle("t3");
        chk("t3_nacc", accIp.size(), 5);
        chk("t3_ip0", accIpAt(0), 64'h1E);
        chk("t3_ip1", accIpAt(1), 64'h1F);
        chk("t3_ip2", accIpAt(2), 64'h20);
        chk("t3_brcyc", accCycAt(2), t0 + 5);
        chk("t3_ip3", accIpAt(3), 64'h40);
        chk("t3_tgtcyc", accCycAt(3), t + 3);
        chk("t3_ip4", accIpAt(4), 64'h41);
        chk("t3_rdtgt", readAt(4), 64'h40);
        chk("t3_rdtgtcyc", readCycAt(4), t + 1);

        // both resolution pulses together behave as not taken; stray trigger ignored
        clearLogs();
        start(16'h001E);
        tick();
        iTrigger = 1'b1; iInitialCodeAddress = 16'h0500;
        tick();
        iTrigger = 1'b0;
        tick(4);
        iBranchTaken = 1'b1; iBranchNotTaken = 1'b1; iJumpIp = 16'h0040;
        t = cyc;
        tick();
        iBranchTaken = 1'b0; iBranchNotTaken = 1'b0;
        waitIdle("t4");
        chk("t4_nacc", accIp.size(), 5);
        chk("t4_ip2", accIpAt(2), 64'h20);
        chk("t4_ip3", accIpAt(3), 64'h21);
        chk("t4_ip3cyc", accCycAt(3), t + 3);
        chk("t4_ip4", accIpAt(4), 64'h22);
        chk("t4_rdnext", readAt(4), 64'h21);
        chk("t4_rdnextcyc", readCycAt(4), t + 1);

        // PC wraps from 0xFFFF to 0x0000
        clearLogs();
        start(16'hFFFF);
        waitIdle("t5");
        chk("t5_nacc", accIp.size(), 2);
        chk("t5_ip0", accIpAt(0), 64'hFFFF);
        chk("t5_ip1", accIpAt(1), 64'h0000);
        chk("t5_cyc1", accCycAt(1), t0 + 4);
        chk("t5_ndone", doneCyc.size(), 1);

        // asynchronous reset with three entries queued, then clean restart
        clearLogs();
        iDecodeReady = 1'b0;
        start(16'h0200);
        tick(4);
        chk("t6_prevalid", {63'h0, oInstructionValid}, 64'h1);
        chk("t6_prebusy", {63'h0, oBusy}, 64'h1);
        #1 Reset = 1'b0;
        #1 chkOutputsZero("t6_rst");
        tick();
        Reset = 1'b1;
        tick();
        clearLogs();
        iDecodeReady = 1'b1;
        start(16'h0300);
        waitIdle("t6");
        chk("t6_rd0", readAt(0), 64'h300);
        chk("t6_rd0cyc", readCycAt(0), t0 + 1);
        chk("t6_nacc", accIp.size(), 2);
        chk("t6_ip0", accIpAt(0), 64'h300);
        chk("t6_ip0cyc", accCycAt(0), t0 + 3);
        chk("t6_ip1", accIpAt(1), 64'h301);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
